// File: rtl/usart_echo_fifo.sv
// usart_echo_fifo: single-clock UART receiver -> FIFO -> UART transmitter loopback with cts flow control.
// Optional CR -> CR LF expansion on the echo path when USART_ECHO_CRLF_EN is defined.
module usart_echo_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CPB_WIDTH  = 12
) (
    input  logic                        comm_clock,
    input  logic                        reset,
    input  logic [CPB_WIDTH-1:0]        clocks_per_bit,
    input  logic                        rx_pin,
    input  logic                        cts,
    output logic                        tx_pin,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        rx_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [CPB_WIDTH-1:0] CNT_ONE = CPB_WIDTH'(1);
`ifdef USART_ECHO_CRLF_EN
    localparam logic [DATA_BITS-1:0] CR_WORD = DATA_BITS'(8'h0D);
    localparam logic [DATA_BITS-1:0] LF_WORD = DATA_BITS'(8'h0A);
`endif

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
`ifdef USART_ECHO_CRLF_EN
        , RX_EXPAND
`endif
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Receive path
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_prev;
    logic                 rx_fall;
    rx_state_t            rx_state;
    logic [CPB_WIDTH-1:0] rx_cpb;
    logic [CPB_WIDTH-1:0] rx_cnt;
    logic [BW-1:0]        rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 push_valid;
    logic [DATA_BITS-1:0] push_data;

    // FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 full;
    logic                 pop;
    logic                 do_push;
    logic [DATA_BITS-1:0] pop_data;

    // Transmit path
    tx_state_t            tx_state;
    logic [CPB_WIDTH-1:0] tx_cpb;
    logic [CPB_WIDTH-1:0] tx_cnt;
    logic [BW-1:0]        tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_last;
    logic                 tx_ready;

    assign rx_fall = rx_prev & ~rx_s2;

    always_ff @(posedge comm_clock) begin
        if (reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cpb     <= '0;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            push_valid <= 1'b0;
            push_data  <= '0;
            rx_error   <= 1'b0;
        end else begin
            rx_s1      <= rx_pin;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            push_valid <= 1'b0;
            rx_error   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= RX_START;
                        rx_cpb   <= clocks_per_bit;
                        rx_cnt   <= CNT_ONE;
                    end
                end
                RX_START: begin
                    // Half a bit in: a line back high means the falling edge was a glitch.
                    if (rx_cnt == (rx_cpb >> 1)) begin
                        rx_cnt   <= CNT_ONE;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == rx_cpb) begin
                        rx_cnt   <= CNT_ONE;
                        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == BW'(DATA_BITS-1)) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == rx_cpb) begin
                        if (rx_s2) begin
                            push_valid <= 1'b1;
                            push_data  <= rx_shift;
`ifdef USART_ECHO_CRLF_EN
                            rx_state   <= (rx_shift == CR_WORD) ? RX_EXPAND : RX_IDLE;
`else
                            rx_state   <= RX_IDLE;
`endif
                        end else begin
                            rx_error <= 1'b1;
                            rx_state <= RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s2) begin
                        rx_state <= RX_IDLE;
                    end
                end
`ifdef USART_ECHO_CRLF_EN
                RX_EXPAND: begin
                    // The CR was pushed this cycle; queue the LF and still honour a new start edge.
                    push_valid <= 1'b1;
                    push_data  <= LF_WORD;
                    if (rx_fall) begin
                        rx_state <= RX_START;
                        rx_cpb   <= clocks_per_bit;
                        rx_cnt   <= CNT_ONE;
                    end else begin
                        rx_state <= RX_IDLE;
                    end
                end
`endif
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // push_valid carries no ready: a push into a full FIFO without a same-cycle pop is dropped
    // and flagged; pop is a one-cycle strobe taken whenever the transmitter can accept a word.
    assign full     = (fifo_count == DEPTH_C);
    assign tx_last  = (tx_cnt == tx_cpb);
    assign tx_ready = (tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_last);
    assign pop      = tx_ready && cts && (fifo_count != '0);
    assign do_push  = push_valid && (!full || pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge comm_clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge comm_clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_valid && full && !pop) begin
                overflow <= 1'b1;
            end
            case ({do_push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A pop in the last stop-bit cycle starts the next frame with no idle gap.
    always_ff @(posedge comm_clock) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_pin   <= 1'b1;
            tx_cpb   <= '0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else if (pop) begin
            tx_state <= TX_START;
            tx_pin   <= 1'b0;
            tx_shift <= pop_data;
            tx_cpb   <= clocks_per_bit;
            tx_cnt   <= CNT_ONE;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_pin <= 1'b1;
                end
                TX_START: begin
                    if (tx_last) begin
                        tx_pin   <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= '0;
                        tx_cnt   <= CNT_ONE;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_last) begin
                        tx_cnt <= CNT_ONE;
                        if (tx_bit == BW'(DATA_BITS-1)) begin
                            tx_pin   <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_pin   <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_last) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_pin   <= 1'b1;
                end
            endcase
        end
    end

endmodule
